chase_counter_arbiter: RTL and testbench
========================================

Name: chase_counter_arbiter

Overview:
Owns a leader counter X and a follower counter Y and shares one W-bit incrementer between two requesters, issuing at most one increment per cycle. Guarantees the invariant Y <= X by construction. Provides a catch-up (SYNC) sequence that drives Y up to X. Sits beside the wide-counter formal examples as a bounded-proof target; the invariant is exported for assertion.

Parameters:
W, 400, width of X and Y
CNT_MAX, all-ones of W bits, saturation value of X

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
req_x  input  1  request to increment X; held until granted or dropped
req_y  input  1  request to increment Y; held until granted or dropped
sync_req  input  1  single-cycle pulse requesting Y catch-up to X
gnt_x  output  1  combinational grant; X increments at this edge
gnt_y  output  1  combinational grant; Y increments at this edge
x_out  output  W  current X (registered)
y_out  output  W  current Y (registered)
x_sat  output  1  X == CNT_MAX
busy  output  1  state != RUN
sync_done  output  1  one-cycle pulse, catch-up complete
inv_ok  output  1  !(Y > X); must be 1 in every reachable state

Behaviour:
- Reset (rst=1 at posedge): X=0, Y=0, state=RUN, rr_ptr=X-favoured. Outputs while/after reset: gnt_x=gnt_y=0 during rst, sync_done=0, busy=0, x_sat=0, inv_ok=1. Reset overrides every other input, including mid-SYNC.
- Eligibility (RUN only): elig_x = req_x && (X != CNT_MAX); elig_y = req_y && (Y < X), unsigned compare.
- Arbitration: only one eligible -> grant it. Both eligible -> round-robin: grant the side not granted most recently; rr_ptr updates only on an actual grant; the pointer after reset grants X first. gnt_x and gnt_y never both 1.
- Update: granted counter increments by 1 at the same posedge; new value is visible on x_out/y_out the next cycle (1-cycle latency). No wrap: X saturates at CNT_MAX, and Y is bounded below X.
- FSM states: RUN, SYNC, DONE.
  - RUN: arbitrate. If sync_req=1, go to SYNC; no grant is issued that cycle because sync_req has priority over requests.
  - SYNC: gnt_x=gnt_y=0. If Y != X, Y <= Y+1 and stay in SYNC. If Y == X, go to DONE with no increment.
  - DONE: sync_done=1, no grants, next state RUN.
  - sync_req in SYNC or DONE is ignored. Requests arriving during SYNC/DONE are not lost; they are arbitrated once the FSM is back in RUN, provided they are still held.
- Catch-up latency from the sync_req cycle with X-Y=k: k+1 cycles in SYNC, then 1 cycle in DONE.
- X does not change in SYNC or DONE.
- inv_ok and x_sat are combinational from registered X and Y.

Test Plan (W=3, CNT_MAX=7):
1. rst high for 2 cycles, then low, no requests -> X=Y=0, gnt_x=gnt_y=0, busy=0, inv_ok=1, held indefinitely.
2. req_x held for 9 cycles -> gnt_x=1 for 7 cycles, X goes 1..7; then gnt_x=0, x_sat=1, X stays 7.
3. From reset, req_y held alone -> gnt_y never asserts, Y stays 0 because Y<X is false.
4. From reset, req_x and req_y both held -> grant order x,y,x,y,... with (X,Y) = (1,0),(1,1),(2,1),...,(7,6); then y alone to (7,7); then no grants; inv_ok=1 throughout.
5. X=5, Y=2, sync_req pulsed together with req_x -> no gnt_x that cycle; 4 SYNC cycles with Y going 3,4,5 and the last cycle idle; sync_done=1 for 1 cycle; busy=1 for 5 cycles; X stays 5; then RUN resumes and the held req_x is granted.
6. rst asserted in the 2nd SYNC cycle -> next cycle state=RUN, X=Y=0, sync_done=0, busy=0.

Source files
------------

// File: rtl/chase_counter_arbiter.sv
// Leader counter X and follower counter Y sharing one incrementer; Y never passes X.
// A SYNC sequence walks Y up to X and reports completion with a one-cycle pulse.
module chase_counter_arbiter #(
  parameter int unsigned W = 400,
  parameter logic [W-1:0] CNT_MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_x,
  input  logic         req_y,
  input  logic         sync_req,
  output logic         gnt_x,
  output logic         gnt_y,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic         x_sat,
  output logic         busy,
  output logic         sync_done,
  output logic         inv_ok
);

  typedef enum logic [1:0] {RUN, SYNC, DONE} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q;
  logic [W-1:0] x_q, y_q;
  logic [W-1:0] x_d, y_d;
  logic         rr_q;
  logic         arb_en, elig_x, elig_y;

  // rr_q == 0 favours X when both sides are eligible
  always_comb begin
    arb_en = !rst && (state_q == RUN) && !sync_req;
    elig_x = req_x && (x_q != CNT_MAX);
    elig_y = req_y && (y_q < x_q);
    gnt_x  = arb_en && elig_x && (!elig_y || !rr_q);
    gnt_y  = arb_en && elig_y && (!elig_x || rr_q);
    x_d    = x_q + ONE;
    y_d    = y_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      x_q     <= '0;
      y_q     <= '0;
      rr_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (sync_req) begin
            state_q <= SYNC;
          end else if (gnt_x) begin
            x_q  <= x_d;
            rr_q <= 1'b1;
          end else if (gnt_y) begin
            y_q  <= y_d;
            rr_q <= 1'b0;
          end
        end
        SYNC: begin
          if (y_q != x_q) y_q <= y_d;
          else            state_q <= DONE;
        end
        DONE:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign x_sat     = (x_q == CNT_MAX);
  assign busy      = (state_q != RUN);
  assign sync_done = (state_q == DONE);
  assign inv_ok    = !(y_q > x_q);

endmodule

// File: tb/tb_chase_counter_arbiter.sv
// Directed vector bench for chase_counter_arbiter at W=3.
module tb_chase_counter_arbiter;

  localparam int W = 3;

  logic         clk, rst, req_x, req_y, sync_req;
  logic         gnt_x, gnt_y, x_sat, busy, sync_done, inv_ok;
  logic [W-1:0] x_out, y_out;

  chase_counter_arbiter #(.W(W), .CNT_MAX(3'd7)) dut (
    .clk(clk), .rst(rst), .req_x(req_x), .req_y(req_y), .sync_req(sync_req),
    .gnt_x(gnt_x), .gnt_y(gnt_y), .x_out(x_out), .y_out(y_out),
    .x_sat(x_sat), .busy(busy), .sync_done(sync_done), .inv_ok(inv_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst, rx, ry, sr;
    logic         gx, gy;
    logic [W-1:0] x, y;
    logic         sat, busy, done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void v(input logic r, rx, ry, sr, gx, gy,
                            input logic [W-1:0] x, y,
                            input logic sat, bz, dn);
    vec_t t;
    t.rst = r; t.rx = rx; t.ry = ry; t.sr = sr;
    t.gx = gx; t.gy = gy; t.x = x; t.y = y;
    t.sat = sat; t.busy = bz; t.done = dn;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // second reset cycle, then idle
    v(1,1,1,0, 0,0,0,0,0,0,0);
    repeat (3) v(0,0,0,0, 0,0,0,0,0,0,0);
    // req_x alone to saturation
    for (int i = 0; i < 7; i++) v(0,1,0,0, 1,0,3'(i),0,0,0,0);
    repeat (2) v(0,1,0,0, 0,0,7,0,1,0,0);
    v(0,0,0,0, 0,0,7,0,1,0,0);
    // reset, then req_y alone never granted
    v(1,1,1,0, 0,0,7,0,1,0,0);
    repeat (3) v(0,0,1,0, 0,0,0,0,0,0,0);
    // both held: alternating grants, then y alone, then nothing
    v(1,0,0,0, 0,0,0,0,0,0,0);
    for (int i = 0; i < 7; i++) begin
      v(0,1,1,0, 1,0,3'(i),3'(i),0,0,0);
      v(0,1,1,0, 0,1,3'(i+1),3'(i),(i == 6),0,0);
    end
    repeat (2) v(0,1,1,0, 0,0,7,7,1,0,0);
    // build X=5, Y=2
    v(1,0,0,0, 0,0,7,7,1,0,0);
    for (int i = 0; i < 5; i++) v(0,1,0,0, 1,0,3'(i),0,0,0,0);
    v(0,0,1,0, 0,1,5,0,0,0,0);
    v(0,0,1,0, 0,1,5,1,0,0,0);
    // sync_req beats held req_x; 4 SYNC cycles, DONE ignores a second sync_req
    v(0,1,0,1, 0,0,5,2,0,0,0);
    v(0,1,0,0, 0,0,5,2,0,1,0);
    v(0,1,0,0, 0,0,5,3,0,1,0);
    v(0,1,0,0, 0,0,5,4,0,1,0);
    v(0,1,0,0, 0,0,5,5,0,1,0);
    v(0,1,0,1, 0,0,5,5,0,1,1);
    v(0,1,0,0, 1,0,5,5,0,0,0);
    v(0,0,0,0, 0,0,6,5,0,0,0);
    // reset during the second SYNC cycle
    v(0,0,0,1, 0,0,6,5,0,0,0);
    v(0,0,0,0, 0,0,6,5,0,1,0);
    v(1,1,0,0, 0,0,6,6,0,1,0);
    v(0,0,0,0, 0,0,0,0,0,0,0);
    // catch-up with X==Y: one SYNC cycle then DONE
    v(0,0,0,1, 0,0,0,0,0,0,0);
    v(0,0,0,0, 0,0,0,0,0,1,0);
    v(0,0,0,0, 0,0,0,0,0,1,1);
    v(0,0,0,0, 0,0,0,0,0,0,0);

    // first reset cycle: state unknown, only grants are defined
    rst = 1'b1; req_x = 1'b1; req_y = 1'b1; sync_req = 1'b0;
    #1;
    chk("gnt_x_in_rst", -1, 32'(gnt_x), 0);
    chk("gnt_y_in_rst", -1, 32'(gnt_y), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req_x = vecs[i].rx; req_y = vecs[i].ry; sync_req = vecs[i].sr;
      #1;
      chk("gnt_x",     i, 32'(gnt_x),     32'(vecs[i].gx));
      chk("gnt_y",     i, 32'(gnt_y),     32'(vecs[i].gy));
      chk("x_out",     i, 32'(x_out),     32'(vecs[i].x));
      chk("y_out",     i, 32'(y_out),     32'(vecs[i].y));
      chk("x_sat",     i, 32'(x_sat),     32'(vecs[i].sat));
      chk("busy",      i, 32'(busy),      32'(vecs[i].busy));
      chk("sync_done", i, 32'(sync_done), 32'(vecs[i].done));
      chk("inv_ok",    i, 32'(inv_ok),    1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
